// File: rtl/bsg_mul_accum_pkg.sv
// Shared types and sizing helpers for the bsg_mul product accumulator.
package bsg_mul_accum_pkg;

    typedef enum logic {
        eACC = 1'b0,
        eOUT = 1'b1
    } bsg_mul_accum_state_e;

    // Eight guard bits above the full product width.
    function automatic int bsg_mul_accum_acc_width(input int width_p);
        return 2 * width_p + 8;
    endfunction

    function automatic int bsg_mul_accum_cnt_width(input int max_els_p);
        return $clog2(max_els_p + 1);
    endfunction

endpackage

// File: rtl/bsg_mul_accum_if.sv
// Product-beat input and valid/yumi result bundle of the accumulator stage.
interface bsg_mul_accum_if
    import bsg_mul_accum_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int acc_width_p = bsg_mul_accum_acc_width(width_p),
    parameter int cnt_width_p = bsg_mul_accum_cnt_width(256)
);
    logic                   v_i;
    logic [2*width_p-1:0]   prod_i;
    logic                   signed_i;
    logic                   last_i;
    logic                   ready_o;
    logic                   v_o;
    logic [acc_width_p-1:0] data_o;
    logic [cnt_width_p-1:0] cnt_o;
    logic                   ovf_o;
    logic                   yumi_i;

    modport slave (
        input  v_i, prod_i, signed_i, last_i, yumi_i,
        output ready_o, v_o, data_o, cnt_o, ovf_o
    );

    modport master (
        output v_i, prod_i, signed_i, last_i, yumi_i,
        input  ready_o, v_o, data_o, cnt_o, ovf_o
    );
endinterface

// File: rtl/bsg_mul_accum_add.sv
// Extends one product to accumulator width, adds it and flags leaving the range.
module bsg_mul_accum_add
    import bsg_mul_accum_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int acc_width_p = bsg_mul_accum_acc_width(width_p)
) (
    input  logic [acc_width_p-1:0] acc_i,
    input  logic [2*width_p-1:0]   prod_i,
    input  logic                   is_signed_i,
    input  logic                   first_i,
    output logic [acc_width_p-1:0] sum_o,
    output logic                   ovf_inc_o
);
    localparam int msb_lp = acc_width_p - 1;

    logic [acc_width_p-1:0] p_s;
    logic [acc_width_p:0]   wide_s;

    // The first beat of a group loads the product and never flags overflow.
    always_comb begin
        p_s       = {acc_width_p{1'b0}};
        wide_s    = {(acc_width_p + 1){1'b0}};
        sum_o     = {acc_width_p{1'b0}};
        ovf_inc_o = 1'b0;
        if (is_signed_i) begin
            p_s = acc_width_p'($signed(prod_i));
        end else begin
            p_s = acc_width_p'(prod_i);
        end
        wide_s = {1'b0, acc_i} + {1'b0, p_s};
        if (first_i) begin
            sum_o     = p_s;
            ovf_inc_o = 1'b0;
        end else if (is_signed_i) begin
            sum_o     = wide_s[msb_lp:0];
            ovf_inc_o = (acc_i[msb_lp] == p_s[msb_lp]) & (wide_s[msb_lp] != acc_i[msb_lp]);
        end else begin
            sum_o     = wide_s[msb_lp:0];
            ovf_inc_o = wide_s[acc_width_p];
        end
    end
endmodule

// File: rtl/bsg_mul_accum_chk.sv
// Protocol properties of the accumulator's result handshake.
module bsg_mul_accum_chk (
    input logic clk_i,
    input logic reset_i,
    input logic ready_o,
    input logic v_o,
    input logic yumi_i
);
    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
    ready_excludes_valid: assert property (@(posedge clk_i) disable iff (reset_i) ready_o != v_o);
endmodule

// File: rtl/bsg_mul_accum.sv
// Sums groups of bsg_mul products and offers sum, element count and sticky
// overflow on a valid/yumi interface; one bubble cycle separates groups.
module bsg_mul_accum
    import bsg_mul_accum_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int acc_width_p = bsg_mul_accum_acc_width(width_p),
    parameter int max_els_p   = 256
) (
    input  logic            clk_i,
    input  logic            reset_i,
    bsg_mul_accum_if.slave  bus
);
    localparam int cnt_width_lp = bsg_mul_accum_cnt_width(max_els_p);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_els_p);

    bsg_mul_accum_state_e    state_r, state_n;
    logic                    ready_s, v_s;
    logic                    first_r, signed_r;
    logic [acc_width_p-1:0]  acc_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    ovf_r;
    logic                    accept_s, grp_signed_s, ovf_inc_s;
    logic [acc_width_p-1:0]  sum_s;

    assign accept_s     = bus.v_i & ready_s;
    assign grp_signed_s = first_r ? bus.signed_i : signed_r;

    bsg_mul_accum_add #(
        .width_p     (width_p),
        .acc_width_p (acc_width_p)
    ) add (
        .acc_i       (acc_r),
        .prod_i      (bus.prod_i),
        .is_signed_i (grp_signed_s),
        .first_i     (first_r),
        .sum_o       (sum_s),
        .ovf_inc_o   (ovf_inc_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eACC;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state.
    always_comb begin
        state_n = state_r;
        case (state_r)
            eACC: begin
                if (accept_s && bus.last_i) begin
                    state_n = eOUT;
                end else begin
                    state_n = eACC;
                end
            end
            eOUT: begin
                if (bus.yumi_i) begin
                    state_n = eACC;
                end else begin
                    state_n = eOUT;
                end
            end
            default: state_n = eACC;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        ready_s = 1'b0;
        v_s     = 1'b0;
        case (state_r)
            eACC:    ready_s = 1'b1;
            eOUT:    v_s     = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Accumulator, saturating count, sticky overflow and latched group signedness.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_r    <= {acc_width_p{1'b0}};
            cnt_r    <= {cnt_width_lp{1'b0}};
            ovf_r    <= 1'b0;
            first_r  <= 1'b1;
            signed_r <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= sum_s;
            ovf_r    <= (ovf_r & ~first_r) | ovf_inc_s;
            first_r  <= bus.last_i;
            signed_r <= grp_signed_s;
            if (first_r) begin
                cnt_r <= cnt_width_lp'(1);
            end else if (cnt_r != cnt_max_lp) begin
                cnt_r <= cnt_r + cnt_width_lp'(1);
            end
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.v_o     = v_s;
    assign bus.data_o  = acc_r;
    assign bus.cnt_o   = cnt_r;
    assign bus.ovf_o   = ovf_r;
endmodule

// File: tb/tb_bsg_mul_accum.sv
// Directed and randomized checks of bsg_mul_accum (width 8, acc 20, max 256).
module tb_bsg_mul_accum;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bsg_mul_accum_if #(.width_p(8), .acc_width_p(20), .cnt_width_p(9)) bus ();

    bsg_mul_accum #(.width_p(8), .acc_width_p(20), .max_els_p(256)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    bsg_mul_accum_chk chk (
        .clk_i   (clk),
        .reset_i (reset),
        .ready_o (bus.ready_o),
        .v_o     (bus.v_o),
        .yumi_i  (bus.yumi_i)
    );

    task automatic send_beat(input logic [15:0] p, input logic s, input logic l, input int idle);
        int guard;
        repeat (idle) begin
            bus.v_i    = 1'b0;
            bus.prod_i = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.v_i = 1'b1; bus.prod_i = p; bus.signed_i = s; bus.last_i = l;
        guard = 0;
        while (!bus.ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_vec++;
        if (guard >= 50) begin
            $display("FAIL beat_accept: ready_o=%b stayed low, required 1", bus.ready_o);
            n_err++;
        end
        @(posedge clk); #1;
        bus.v_i = 1'b0; bus.last_i = 1'b0;
    endtask

    // Samples the offered result, idles with garbage beats, then consumes it.
    task automatic take_result(input int delay, output logic v, output logic [19:0] d,
                               output logic [8:0] c, output logic o);
        v = bus.v_o; d = bus.data_o; c = bus.cnt_o; o = bus.ovf_o;
        repeat (delay) begin
            bus.v_i = 1'($urandom); bus.prod_i = 16'($urandom); bus.last_i = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.v_i = 1'b0; bus.last_i = 1'b0;
        if (bus.v_o) begin
            bus.yumi_i = 1'b1;
            @(posedge clk); #1;
            bus.yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.v_i = 1'b0; bus.prod_i = 16'h0; bus.signed_i = 1'b0; bus.last_i = 1'b0; bus.yumi_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++;
        if ({bus.ready_o, bus.v_o, bus.data_o, bus.cnt_o, bus.ovf_o} !== {1'b1, 1'b0, 20'd0, 9'd0, 1'b0}) begin
            $display("FAIL reset: rdy=%b v=%b d=%0d c=%0d o=%b, required 1 0 0 0 0",
                     bus.ready_o, bus.v_o, bus.data_o, bus.cnt_o, bus.ovf_o);
            n_err++;
        end
    endtask

    task automatic test_unsigned();
        logic v, o; logic [19:0] d; logic [8:0] c;
        send_beat(16'd40000, 1'b0, 1'b0, 0);
        send_beat(16'd40000, 1'b0, 1'b0, 0);
        send_beat(16'd40000, 1'b0, 1'b1, 0);
        take_result(0, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'd120000, 9'd3, 1'b0}) begin
            $display("FAIL unsigned3: v=%b d=%0d c=%0d o=%b, required 1 120000 3 0", v, d, c, o);
            n_err++;
        end
    endtask

    task automatic test_signed();
        logic v, o; logic [19:0] d; logic [8:0] c;
        send_beat(16'h4000, 1'b1, 1'b0, 0);
        send_beat(16'hFFFA, 1'b0, 1'b1, 0);
        take_result(1, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'h03FFA, 9'd2, 1'b0}) begin
            $display("FAIL signed2: v=%b d=%h c=%0d o=%b, required 1 03ffa 2 0", v, d, c, o);
            n_err++;
        end
    endtask

    task automatic test_overflow();
        logic v, o; logic [19:0] d; logic [8:0] c;
        for (int i = 0; i < 27; i++) send_beat(16'd65025, 1'b0, (i == 26), 0);
        take_result(0, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'd707099, 9'd27, 1'b1}) begin
            $display("FAIL ovf27: v=%b d=%0d c=%0d o=%b, required 1 707099 27 1", v, d, c, o);
            n_err++;
        end
        send_beat(16'd1, 1'b0, 1'b1, 0);
        take_result(0, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'd1, 9'd1, 1'b0}) begin
            $display("FAIL ovf_clear: v=%b d=%0d c=%0d o=%b, required 1 1 1 0", v, d, c, o);
            n_err++;
        end
    endtask

    task automatic test_hold();
        send_beat(16'd5, 1'b0, 1'b1, 0);
        n_vec++;
        if ({bus.v_o, bus.cnt_o, bus.data_o} !== {1'b1, 9'd1, 20'd5}) begin
            $display("FAIL single: v=%b c=%0d d=%0d, required 1 1 5", bus.v_o, bus.cnt_o, bus.data_o);
            n_err++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.v_i = 1'b1; bus.prod_i = 16'hABCD; bus.last_i = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if ({bus.ready_o, bus.v_o, bus.data_o, bus.cnt_o, bus.ovf_o} !== {1'b0, 1'b1, 20'd5, 9'd1, 1'b0}) begin
                $display("FAIL hold%0d: rdy=%b v=%b d=%0d c=%0d o=%b, required 0 1 5 1 0", i,
                         bus.ready_o, bus.v_o, bus.data_o, bus.cnt_o, bus.ovf_o);
                n_err++;
            end
        end
        bus.v_i = 1'b0; bus.last_i = 1'b0; bus.yumi_i = 1'b1;
        @(posedge clk); #1;
        bus.yumi_i = 1'b0;
        n_vec++;
        if ({bus.ready_o, bus.v_o} !== 2'b10) begin
            $display("FAIL after_yumi: rdy=%b v=%b, required 1 0", bus.ready_o, bus.v_o);
            n_err++;
        end
    endtask

    task automatic test_mid_reset();
        logic v, o; logic [19:0] d; logic [8:0] c;
        send_beat(16'd100, 1'b0, 1'b0, 0);
        send_beat(16'd200, 1'b0, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({bus.v_o, bus.ready_o, bus.cnt_o} !== {1'b0, 1'b1, 9'd0}) begin
                $display("FAIL mid_reset%0d: v=%b rdy=%b c=%0d, required 0 1 0", i, bus.v_o, bus.ready_o, bus.cnt_o);
                n_err++;
            end
            @(posedge clk); #1;
        end
        send_beat(16'd7, 1'b0, 1'b0, 0);
        send_beat(16'd8, 1'b0, 1'b1, 0);
        take_result(0, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'd15, 9'd2, 1'b0}) begin
            $display("FAIL post_reset: v=%b d=%0d c=%0d o=%b, required 1 15 2 0", v, d, c, o);
            n_err++;
        end
    endtask

    task automatic test_saturate();
        logic v, o; logic [19:0] d; logic [8:0] c;
        for (int i = 0; i < 300; i++) send_beat(16'd1, 1'b0, (i == 299), 0);
        take_result(0, v, d, c, o);
        n_vec++;
        if ({v, d, c, o} !== {1'b1, 20'd300, 9'd256, 1'b0}) begin
            $display("FAIL saturate: v=%b d=%0d c=%0d o=%b, required 1 300 256 0", v, d, c, o);
            n_err++;
        end
    endtask

    // Exact-integer reference: the running value is kept in range and any
    // single step that leaves the signed or unsigned 20-bit range sets ovf.
    task automatic test_random();
        logic v, o; logic [19:0] d; logic [8:0] c;
        longint a, pv, s;
        logic [15:0] p;
        logic gs, sg, ex_o;
        int len, ex_c;
        logic [19:0] ex_d;
        for (int g = 0; g < 10000; g++) begin
            len = $urandom_range(1, 4);
            a = 0; ex_o = 1'b0; ex_c = 0; gs = 1'b0;
            for (int k = 0; k < len; k++) begin
                p  = 16'($urandom);
                sg = 1'($urandom);
                if (k == 0) gs = sg;
                pv = gs ? longint'($signed(p)) : longint'(p);
                if (k == 0) begin
                    a = pv; ex_c = 1;
                end else begin
                    s = a + pv;
                    if (gs) begin
                        if (s < -524288 || s > 524287) ex_o = 1'b1;
                        if (s > 524287) s -= 1048576;
                        if (s < -524288) s += 1048576;
                    end else begin
                        if (s >= 1048576) begin
                            ex_o = 1'b1;
                            s -= 1048576;
                        end
                    end
                    a = s;
                    if (ex_c < 256) ex_c++;
                end
                send_beat(p, sg, (k == len - 1), $urandom_range(0, 1));
            end
            ex_d = a[19:0];
            take_result($urandom_range(0, 2), v, d, c, o);
            n_vec++;
            if ({v, d, c, o} !== {1'b1, ex_d, 9'(ex_c), ex_o}) begin
                $display("FAIL random g%0d: v=%b d=%h c=%0d o=%b, required 1 %h %0d %b",
                         g, v, d, c, o, ex_d, ex_c, ex_o);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_hold();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
